dac_sample_pattern_gen: RTL and testbench



---
 rtl/dac_sample_pattern_gen_pkg.sv | 42 ++++
 rtl/dac_sample_pattern_gen.sv | 126 ++++++++++++
 tb/tb_dac_sample_pattern_gen.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/dac_sample_pattern_gen_pkg.sv
// Shared types for the DAC sample pattern generator: pattern modes, FSM states
// and the per-sample pattern function.
package dac_sample_pattern_gen_pkg;

   typedef enum logic [1:0] {
      MODE_INTERLEAVED_INC = 2'd0,
      MODE_CHANNEL_RAMP    = 2'd1,
      MODE_CONSTANT        = 2'd2,
      MODE_TOGGLE          = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam int unsigned BEAT_CNT_WIDTH = 16;

   // Computed at 32 bits; callers keep the low SAMPLE_WIDTH bits, which gives
   // modulo-2^SAMPLE_WIDTH wrap for free.
   function automatic logic [31:0] pattern_sample(
      input mode_e       m,
      input logic [31:0] base,
      input logic [31:0] start,
      input logic        odd_beat,
      input logic [31:0] inc_off,
      input logic [31:0] ramp_off
   );
      logic [31:0] result;
      result = start;
      unique case (m)
         MODE_INTERLEAVED_INC: result = base + inc_off;
         MODE_CHANNEL_RAMP:    result = base + ramp_off;
         MODE_CONSTANT:        result = start;
         MODE_TOGGLE:          result = odd_beat ? ~start : start;
         default:              result = start;
      endcase
      return result;
   endfunction

endpackage

// File: rtl/dac_sample_pattern_gen.sv
// Multi-channel DAC test-pattern source: emits beats of NUM_CHANNELS x
// SAMPLES_PER_CHANNEL samples under valid/ready, continuous or in finite bursts.
module dac_sample_pattern_gen
   import dac_sample_pattern_gen_pkg::*;
#(
   parameter int unsigned NUM_CHANNELS        = 8,
   parameter int unsigned SAMPLES_PER_CHANNEL = 2,
   parameter int unsigned SAMPLE_WIDTH        = 16
) (
   input  logic                                                  clk,
   input  logic                                                  rst,
   input  logic                                                  run,
   input  logic [1:0]                                            mode,
   input  logic [SAMPLE_WIDTH-1:0]                               start_value,
   input  logic [15:0]                                           burst_len,
   input  logic [NUM_CHANNELS-1:0]                               enable,
   input  logic                                                  out_ready,
   output logic                                                  out_valid,
   output logic [NUM_CHANNELS*SAMPLES_PER_CHANNEL*SAMPLE_WIDTH-1:0] out_data,
   output logic                                                  active,
   output logic                                                  burst_done
);

   localparam logic [SAMPLE_WIDTH-1:0] INC_STEP  = SAMPLE_WIDTH'(NUM_CHANNELS*SAMPLES_PER_CHANNEL);
   localparam logic [SAMPLE_WIDTH-1:0] RAMP_STEP = SAMPLE_WIDTH'(SAMPLES_PER_CHANNEL);

   state_e                      state_q, state_d;
   mode_e                       mode_q;
   logic [SAMPLE_WIDTH-1:0]     start_q;
   logic [SAMPLE_WIDTH-1:0]     base_q;
   logic [SAMPLE_WIDTH-1:0]     base_step;
   logic [BEAT_CNT_WIDTH-1:0]   burst_len_q;
   logic [BEAT_CNT_WIDTH-1:0]   beat_cnt_q;
   logic                        capture;
   logic                        transfer;
   logic                        last_beat;

   assign transfer  = out_valid && out_ready;
   assign last_beat = (burst_len_q != '0) && ((beat_cnt_q + 16'd1) == burst_len_q);

   // NOTE: every output of this block is given a default first so no path
   // leaves a variable unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d    = state_q;
      capture    = 1'b0;
      out_valid  = 1'b0;
      active     = 1'b0;
      burst_done = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (run) begin
               state_d = ST_RUN;
               capture = 1'b1;
            end
         end
         ST_RUN: begin
            out_valid = 1'b1;
            active    = 1'b1;
            if (transfer) begin
               if (last_beat) begin
                  state_d    = ST_DONE;
                  burst_done = 1'b1;
               end else if (!run) begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_DONE: begin
            if (!run) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      base_step = '0;
      unique case (mode_q)
         MODE_INTERLEAVED_INC: base_step = INC_STEP;
         MODE_CHANNEL_RAMP:    base_step = RAMP_STEP;
         default:              base_step = '0;
      endcase
   end

   // Configuration is frozen at RUN entry; later input changes are ignored.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q      <= MODE_INTERLEAVED_INC;
         start_q     <= '0;
         burst_len_q <= '0;
         base_q      <= '0;
         beat_cnt_q  <= '0;
      end else if (capture) begin
         mode_q      <= mode_e'(mode);
         start_q     <= start_value;
         burst_len_q <= burst_len;
         base_q      <= start_value;
         beat_cnt_q  <= '0;
      end else if (transfer) begin
         base_q     <= base_q + base_step;
         beat_cnt_q <= beat_cnt_q + 16'd1;
      end
   end

   // Data is a pure function of registered beat state, so it cannot move
   // while a beat is stalled; only enable is applied live.
   for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
      for (genvar j = 0; j < SAMPLES_PER_CHANNEL; j++) begin : g_slot
         localparam logic [31:0] INC_OFF  = 32'(NUM_CHANNELS*j + i);
         localparam logic [31:0] RAMP_OFF = 32'(j);
         logic [SAMPLE_WIDTH-1:0] sample;

         assign sample = SAMPLE_WIDTH'(pattern_sample(mode_q, 32'(base_q), 32'(start_q),
                                                      beat_cnt_q[0], INC_OFF, RAMP_OFF));
         assign out_data[SAMPLE_WIDTH*(SAMPLES_PER_CHANNEL*i+j) +: SAMPLE_WIDTH] =
            (out_valid && enable[i]) ? sample : '0;
      end
   end

endmodule

// File: tb/tb_dac_sample_pattern_gen.sv
// Directed self-checking bench for dac_sample_pattern_gen at 8 ch x 2 slots x 16 bit.
module tb_dac_sample_pattern_gen;

   logic         clk = 1'b0;
   logic         rst;
   logic         run;
   logic [1:0]   mode;
   logic [15:0]  start_value;
   logic [15:0]  burst_len;
   logic [7:0]   enable;
   logic         out_ready;
   logic         out_valid;
   logic [255:0] out_data;
   logic         active;
   logic         burst_done;

   int errors = 0;
   int checks = 0;

   dac_sample_pattern_gen #(
      .NUM_CHANNELS(8), .SAMPLES_PER_CHANNEL(2), .SAMPLE_WIDTH(16)
   ) dut (
      .clk(clk), .rst(rst), .run(run), .mode(mode), .start_value(start_value),
      .burst_len(burst_len), .enable(enable), .out_ready(out_ready),
      .out_valid(out_valid), .out_data(out_data), .active(active),
      .burst_done(burst_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] smp(input int ch, input int slot);
      return out_data[16*(2*ch+slot) +: 16];
   endfunction

   // Advance one clock and settle just after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0; run = 1'b0; mode = 2'd0; start_value = 16'h0; burst_len = 16'd0;
      enable = 8'hFF; out_ready = 1'b1;
      #1 rst = 1'b1;
      #2;
      check("rst_valid", 32'(out_valid), 0);
      check("rst_active", 32'(active), 0);
      check("rst_data_zero", 32'(|out_data), 0);
      check("rst_burst_done", 32'(burst_done), 0);
      step(); step();
      rst = 1'b0;

      // Interleaved increment from 0
      run = 1'b1;
      step();
      check("inc_valid", 32'(out_valid), 1);
      check("inc_active", 32'(active), 1);
      check("inc_b0_ch0s0", 32'(smp(0,0)), 0);
      check("inc_b0_ch0s1", 32'(smp(0,1)), 8);
      check("inc_b0_ch1s0", 32'(smp(1,0)), 1);
      check("inc_b0_ch1s1", 32'(smp(1,1)), 9);
      check("inc_b0_ch7s0", 32'(smp(7,0)), 7);
      check("inc_b0_ch7s1", 32'(smp(7,1)), 15);
      step();
      check("inc_b1_ch0s0", 32'(smp(0,0)), 16);
      check("inc_b1_ch0s1", 32'(smp(0,1)), 24);
      run = 1'b0;
      step();
      check("inc_idle_valid", 32'(out_valid), 0);
      check("inc_idle_data", 32'(|out_data), 0);

      // Wrap near the top of the range
      start_value = 16'hFFF8; run = 1'b1;
      step();
      check("wrap_ch0s1", 32'(smp(0,1)), 32'h0000);
      check("wrap_ch7s0", 32'(smp(7,0)), 32'hFFFF);
      check("wrap_ch7s1", 32'(smp(7,1)), 32'h0007);
      run = 1'b0;
      step();
      check("wrap_idle", 32'(out_valid), 0);

      // Finite burst of 3 with out_ready alternating
      start_value = 16'h0; burst_len = 16'd3; out_ready = 1'b0; run = 1'b1;
      step();
      check("bst_b0_data", 32'(smp(0,0)), 0);
      check("bst_b0_done", 32'(burst_done), 0);
      step();
      check("bst_b0_stall", 32'(smp(0,1)), 8);
      out_ready = 1'b1;
      step();
      check("bst_b1_data", 32'(smp(0,0)), 16);
      out_ready = 1'b0;
      step();
      check("bst_b1_stall", 32'(smp(0,0)), 16);
      out_ready = 1'b1;
      step();
      check("bst_b2_data", 32'(smp(0,0)), 32);
      out_ready = 1'b0;
      #1 check("bst_done_stalled", 32'(burst_done), 0);
      step();
      check("bst_b2_stall", 32'(smp(7,1)), 47);
      out_ready = 1'b1;
      #1 check("bst_done_pulse", 32'(burst_done), 1);
      step();
      check("bst_done_valid", 32'(out_valid), 0);
      check("bst_done_clear", 32'(burst_done), 0);
      check("bst_done_active", 32'(active), 0);
      out_ready = 1'b0;
      step();
      out_ready = 1'b1;
      step();
      check("bst_done_hold", 32'(out_valid), 0);
      run = 1'b0;
      step();
      check("bst_idle", 32'(out_valid), 0);
      run = 1'b1; out_ready = 1'b0;
      step();
      check("bst_restart_valid", 32'(out_valid), 1);
      check("bst_restart_data", 32'(smp(0,1)), 8);
      // run drop with a stalled beat: beat held until accepted
      run = 1'b0;
      step();
      check("drop_hold_valid", 32'(out_valid), 1);
      out_ready = 1'b1;
      step();
      check("drop_idle", 32'(out_valid), 0);
      check("drop_no_done", 32'(burst_done), 0);

      // Channel ramp with partial enable
      mode = 2'd1; start_value = 16'h0100; burst_len = 16'd0; enable = 8'h05; run = 1'b1;
      step();
      check("ramp_b0_ch0s0", 32'(smp(0,0)), 32'h100);
      check("ramp_b0_ch0s1", 32'(smp(0,1)), 32'h101);
      check("ramp_b0_ch2s0", 32'(smp(2,0)), 32'h100);
      check("ramp_b0_ch1s0", 32'(smp(1,0)), 0);
      check("ramp_b0_ch7s1", 32'(smp(7,1)), 0);
      step();
      check("ramp_b1_ch0s0", 32'(smp(0,0)), 32'h102);
      check("ramp_b1_ch2s1", 32'(smp(2,1)), 32'h103);
      check("ramp_b1_ch3s1", 32'(smp(3,1)), 0);
      run = 1'b0;
      step();

      // Toggle, with a mid-run configuration change that must be ignored
      mode = 2'd3; start_value = 16'h00FF; enable = 8'hFF; run = 1'b1;
      step();
      check("tog_b0_ch0s0", 32'(smp(0,0)), 32'h00FF);
      check("tog_b0_ch7s1", 32'(smp(7,1)), 32'h00FF);
      mode = 2'd2; start_value = 16'h1234;
      step();
      check("tog_b1_ch3s1", 32'(smp(3,1)), 32'hFF00);
      check("tog_b1_ch6s0", 32'(smp(6,0)), 32'hFF00);
      step();
      check("tog_b2_ch5s0", 32'(smp(5,0)), 32'h00FF);
      run = 1'b0;
      step();

      // Constant mode
      mode = 2'd2; start_value = 16'hABCD; run = 1'b1;
      step();
      check("const_b0", 32'(smp(4,1)), 32'hABCD);
      step();
      check("const_b1", 32'(smp(0,0)), 32'hABCD);
      run = 1'b0;
      step();

      // Asynchronous reset mid-burst with a stalled beat
      mode = 2'd0; start_value = 16'h0; out_ready = 1'b0; run = 1'b1;
      step();
      step();
      check("pre_rst_valid", 32'(out_valid), 1);
      rst = 1'b1;
      #1;
      check("mid_rst_valid", 32'(out_valid), 0);
      check("mid_rst_active", 32'(active), 0);
      check("mid_rst_data", 32'(|out_data), 0);
      #1 rst = 1'b0;
      out_ready = 1'b1;
      step();
      check("post_rst_ch0s0", 32'(smp(0,0)), 0);
      check("post_rst_ch0s1", 32'(smp(0,1)), 8);
      check("post_rst_ch7s1", 32'(smp(7,1)), 15);
      run = 1'b0;
      step();
      check("final_idle", 32'(out_valid), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
